// File: rtl/dm_copy_engine.sv
// Block copy/fill bus initiator for the single-ported data memory.
// Copies are overlap-safe: direction is picked at command time.
module dm_copy_engine #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic          gnt,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] addr,
  output logic          re,
  output logic          we,
  output logic [DW-1:0] wrt_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] sptr_q;
  logic [AW-1:0] dptr_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] fill_q;
  logic          desc_q;

  logic [AW-1:0] diff;
  logic          desc;
  logic [AW-1:0] sptr_d;
  logic [AW-1:0] dptr_d;

  // Destination inside the source window: walk top-down.
  assign diff   = dst_addr - src_addr;
  assign desc   = !mode && (dst_addr != src_addr) && (diff < len);
  assign sptr_d = desc_q ? sptr_q - AW'(1) : sptr_q + AW'(1);
  assign dptr_d = desc_q ? dptr_q - AW'(1) : dptr_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sptr_q  <= '0;
      dptr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= len;
            fill_q <= fill_val;
            desc_q <= desc;
            if (desc) begin
              sptr_q <= src_addr + len - AW'(1);
              dptr_q <= dst_addr + len - AW'(1);
            end else begin
              sptr_q <= src_addr;
              dptr_q <= dst_addr;
            end
            if (len == '0)  state_q <= DONE;
            else if (mode)  state_q <= FILL;
            else            state_q <= RD;
          end
        end
        RD: begin
          if (gnt) begin
            buf_q   <= rd_data;
            state_q <= WR;
          end
        end
        WR: begin
          if (gnt) begin
            cnt_q   <= cnt_q - AW'(1);
            sptr_q  <= sptr_d;
            dptr_q  <= dptr_d;
            state_q <= (cnt_q == AW'(1)) ? DONE : RD;
          end
        end
        FILL: begin
          if (gnt) begin
            cnt_q   <= cnt_q - AW'(1);
            dptr_q  <= dptr_q + AW'(1);
            state_q <= (cnt_q == AW'(1)) ? DONE : FILL;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr     = '0;
    re       = 1'b0;
    we       = 1'b0;
    wrt_data = '0;
    unique case (state_q)
      RD: begin
        addr = sptr_q;
        re   = gnt;
      end
      WR: begin
        addr     = dptr_q;
        we       = gnt;
        wrt_data = buf_q;
      end
      FILL: begin
        addr     = dptr_q;
        we       = gnt;
        wrt_data = fill_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: 64K-word memory model, memmove/fill
// reference and access-order scoreboard.
module tb_dm_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic [15:0] fill_val;
  logic        gnt;
  logic [15:0] rd_data;
  logic [15:0] addr;
  logic        re;
  logic        we;
  logic [15:0] wrt_data;
  logic        busy;
  logic        done;

  logic        init_req;
  logic [15:0] mem   [0:65535];
  logic [15:0] exp_m [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_copy_engine #(.AW(16), .DW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .gnt      (gnt),
    .rd_data  (rd_data),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wrt_data (wrt_data),
    .busy     (busy),
    .done     (done)
  );

  assign rd_data = mem[addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'($urandom);
    end else if (we) begin
      mem[addr] <= wrt_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // gm: 0 = grant always, 1 = random grant + junk commands, 2 = 1,0,0,1
  task automatic run(input string tag, input logic m, input logic [15:0] s,
                     input logic [15:0] d, input logic [15:0] n,
                     input logic [15:0] fv, input int gm);
    logic [16:0] q[$];
    logic [15:0] tmp[$];
    logic [16:0] f;
    logic [15:0] a;
    logic [15:0] diff;
    logic [3:0]  pat;
    logic        ovl;
    int          errs;
    int          acc;
    int          donek;
    int          budget;
    int          mism;
    int          want_acc;
    pat   = 4'b1001;
    errs  = 0;
    acc   = 0;
    donek = 0;
    for (int i = 0; i < 65536; i++) exp_m[i] = mem[i];
    diff = d - s;
    ovl  = (d != s) && (diff < n);
    if (m) begin
      for (int i = 0; i < int'(n); i++) begin
        a = d + 16'(i);
        exp_m[a] = fv;
        q.push_back({1'b1, a});
      end
      want_acc = int'(n);
    end else begin
      for (int i = 0; i < int'(n); i++) tmp.push_back(mem[16'(s + 16'(i))]);
      for (int i = 0; i < int'(n); i++) exp_m[16'(d + 16'(i))] = tmp[i];
      for (int j = 0; j < int'(n); j++) begin
        int i;
        i = ovl ? int'(n) - 1 - j : j;
        q.push_back({1'b0, 16'(s + 16'(i))});
        q.push_back({1'b1, 16'(d + 16'(i))});
      end
      want_acc = 2 * int'(n);
    end
    budget = 20 * int'(n) + 20;
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d;
    len = n; fill_val = fv; gnt = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (gm == 0) gnt = 1'b1;
      else if (gm == 2) gnt = pat[(k - 1) % 4];
      else begin
        gnt = ($urandom_range(0, 3) != 0);
        start = 1'($urandom);
        mode = 1'($urandom);
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        len = 16'($urandom);
        fill_val = 16'($urandom);
      end
      #1;
      if (re && we) errs++;
      if (!gnt && (re || we)) errs++;
      if (busy !== 1'b1) errs++;
      if (re || we) begin
        acc++;
        if (q.size() == 0) errs++;
        else begin
          f = q.pop_front();
          if ({we, addr} !== f) errs++;
        end
      end
      if (done === 1'b1) begin
        start = 1'b0;
        if (re || we) errs++;
        donek = k;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(donek != 0), 32'd1);
    chk({tag, "_access_errs"}, 32'(errs), 32'd0);
    chk({tag, "_access_cnt"}, 32'(acc), 32'(want_acc));
    if (gm == 0) chk({tag, "_done_cycle"}, 32'(donek), 32'(want_acc + 1));
    @(negedge clk);
    gnt = 1'b1;
    #1;
    chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_m[i]) mism++;
    chk({tag, "_mem"}, 32'(mism), 32'd0);
  endtask

  initial begin
    logic [15:0] old;
    logic [15:0] s;
    logic [15:0] d;
    int          nd;
    rst = 1'b1; init_req = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0; gnt = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ctl", {28'd0, re, we, done, busy}, 32'd0);
    chk("rst_addr", {16'd0, addr}, 32'd0);
    chk("rst_wdata", {16'd0, wrt_data}, 32'd0);
    rst = 1'b0;

    run("copy4", 1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0, 0);
    run("ovl4", 1'b0, 16'h0020, 16'h0022, 16'd4, 16'h0, 0);
    run("fill3", 1'b1, 16'h0000, 16'hFFFE, 16'd3, 16'hBEEF, 0);
    run("stall", 1'b0, 16'h0040, 16'h0200, 16'd6, 16'h0, 2);
    run("len0c", 1'b0, 16'h0050, 16'h0300, 16'd0, 16'h0, 0);
    run("len0f", 1'b1, 16'h0050, 16'h0300, 16'd0, 16'h1234, 0);
    run("wrapc", 1'b0, 16'hFFFD, 16'hFFFF, 16'd5, 16'h0, 0);
    run("same", 1'b0, 16'h0400, 16'h0400, 16'd3, 16'h0, 0);

    old = mem[16'h3000];
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 16'h2000;
    dst_addr = 16'h3000; len = 16'd8; gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_we", {31'd0, we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {29'd0, busy, re, we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("mid_no_done", 32'(nd), 32'd0);
    chk("mid_mem", {16'd0, mem[16'h3000]}, {16'd0, old});
    run("after_rst", 1'b0, 16'h2000, 16'h3000, 16'd8, 16'h0, 0);

    for (int t = 0; t < 10; t++) begin
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 16)) - 16'd8
                                      : 16'($urandom);
      run($sformatf("rnd%0d", t), 1'($urandom), s, d,
          16'($urandom_range(1, 20)), 16'($urandom),
          int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
